ps2_scancode_decoder: RTL

//  Consumer of the ps2_kbd_host RX FIFO. Pops raw set-2 scancode bytes and parses them:
//   E0 prefix, F0 break prefix, 8-byte E1 Pause sequence, fake-shift drop, reply-code filtering.

---
 rtl/ps2_kbd_pkg.sv | 75 +++++++
 rtl/ps2_seq_timer.sv | 28 ++
 rtl/ps2_scancode_decoder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ps2_kbd_pkg.sv
// Shared PS/2 keyboard definitions: scancode constants, modifier bit map,
// decoder state encoding and the Pause-sequence byte table.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_LGUI   = 8'h1F;
  localparam logic [7:0] SC_RGUI   = 8'h27;
  localparam logic [7:0] SC_PAUSE  = 8'h77;

  localparam logic [7:0] RPL_BAT    = 8'hAA;
  localparam logic [7:0] RPL_ACK    = 8'hFA;
  localparam logic [7:0] RPL_RESEND = 8'hFE;
  localparam logic [7:0] RPL_ECHO   = 8'hEE;
  localparam logic [7:0] RPL_ERR0   = 8'h00;
  localparam logic [7:0] RPL_ERRFF  = 8'hFF;

  localparam int unsigned MOD_LSHIFT = 0;
  localparam int unsigned MOD_RSHIFT = 1;
  localparam int unsigned MOD_LCTRL  = 2;
  localparam int unsigned MOD_RCTRL  = 3;
  localparam int unsigned MOD_LALT   = 4;
  localparam int unsigned MOD_RALT   = 5;
  localparam int unsigned MOD_LGUI   = 6;
  localparam int unsigned MOD_RGUI   = 7;

  localparam logic [2:0] PAUSE_LAST = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK,
    ST_PAUSE
  } dec_state_t;

  // Bytes expected after the leading E1, indexed 0..6.
  function automatic logic [7:0] pause_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    pause_byte = 8'h14;
      3'd1:    pause_byte = 8'h77;
      3'd2:    pause_byte = 8'hE1;
      3'd3:    pause_byte = 8'hF0;
      3'd4:    pause_byte = 8'h14;
      3'd5:    pause_byte = 8'hF0;
      default: pause_byte = 8'h77;
    endcase
  endfunction

  function automatic logic is_reply(input logic [7:0] b);
    is_reply = (b == RPL_BAT) || (b == RPL_ACK) || (b == RPL_RESEND) ||
               (b == RPL_ECHO) || (b == RPL_ERR0) || (b == RPL_ERRFF);
  endfunction

  function automatic logic [7:0] mod_mask(input logic [7:0] code, input logic ext);
    mod_mask = '0;
    if (!ext) begin
      if (code == SC_LSHIFT) mod_mask[MOD_LSHIFT] = 1'b1;
      if (code == SC_RSHIFT) mod_mask[MOD_RSHIFT] = 1'b1;
      if (code == SC_CTRL)   mod_mask[MOD_LCTRL]  = 1'b1;
      if (code == SC_ALT)    mod_mask[MOD_LALT]   = 1'b1;
    end else begin
      if (code == SC_CTRL)   mod_mask[MOD_RCTRL]  = 1'b1;
      if (code == SC_ALT)    mod_mask[MOD_RALT]   = 1'b1;
      if (code == SC_LGUI)   mod_mask[MOD_LGUI]   = 1'b1;
      if (code == SC_RGUI)   mod_mask[MOD_RGUI]   = 1'b1;
    end
  endfunction

endpackage

// File: rtl/ps2_seq_timer.sv
// Saturating microsecond counter bounding the gap between bytes of one sequence.
module ps2_seq_timer #(
  parameter int unsigned TIMEOUT_US = 2000
) (
  input  logic clk6x,
  input  logic reset,
  input  logic ck1us,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  import ps2_kbd_pkg::*;

  localparam int unsigned W = $clog2(TIMEOUT_US + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_US);

  logic [W-1:0] cnt;

  always_ff @(posedge clk6x) begin
    if (reset || clr)
      cnt <= '0;
    else if (en && ck1us && (cnt != LIMIT))
      cnt <= cnt + 1'b1;
  end

  assign timeout = (cnt == LIMIT);

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Parses raw set-2 scancode bytes from the PS/2 RX FIFO into key events
// and tracks the held-modifier bitmask.
module ps2_scancode_decoder #(
  parameter int unsigned TIMEOUT_US     = 2000,
  parameter bit          FILTER_REPLIES = 1'b1
) (
  input  logic       clk6x,
  input  logic       reset,
  input  logic       ck1us,
  input  logic [7:0] kbd_rdata_i,
  input  logic       kbd_rvalid_i,
  output logic       kbd_rdeq_o,
  output logic       ev_valid_o,
  input  logic       ev_ready_i,
  output logic [7:0] ev_code_o,
  output logic       ev_ext_o,
  output logic       ev_brk_o,
  output logic [7:0] mod_o,
  output logic       err_o
);
  import ps2_kbd_pkg::*;

  dec_state_t state, state_d;
  logic [2:0] pcnt, pcnt_d;
  logic       bubble, stall, pop, timeout;
  logic       load, ld_ext, ld_brk, err_d;
  logic [7:0] b, ld_mask;

  assign b     = kbd_rdata_i;
  assign stall = ev_valid_o && !ev_ready_i;
  assign pop   = kbd_rvalid_i && !bubble && !stall;
  assign kbd_rdeq_o = pop;

  ps2_seq_timer #(.TIMEOUT_US(TIMEOUT_US)) u_timer (
    .clk6x   (clk6x),
    .reset   (reset),
    .ck1us   (ck1us),
    .clr     (pop || (state == ST_IDLE)),
    .en      (state != ST_IDLE),
    .timeout (timeout)
  );

  always_comb begin
    state_d = state;
    pcnt_d  = pcnt;
    load    = 1'b0;
    ld_ext  = 1'b0;
    ld_brk  = 1'b0;
    err_d   = 1'b0;
    if (pop) begin
      case (state)
        ST_IDLE: begin
          if (b == SC_E0) state_d = ST_EXT;
          else if (b == SC_F0) state_d = ST_BRK;
          else if (b == SC_E1) begin
            state_d = ST_PAUSE;
            pcnt_d  = 3'd1;
          end else if (!(FILTER_REPLIES && is_reply(b))) load = 1'b1;
        end
        ST_EXT: begin
          state_d = ST_IDLE;
          if (b == SC_F0) state_d = ST_EXTBRK;
          else if (b == SC_E0 || b == SC_E1) err_d = 1'b1;
          else if (b != SC_LSHIFT && b != SC_RSHIFT) begin
            load   = 1'b1;
            ld_ext = 1'b1;
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          if (b == SC_E0 || b == SC_E1 || b == SC_F0) err_d = 1'b1;
          else begin
            load   = 1'b1;
            ld_brk = 1'b1;
          end
        end
        ST_EXTBRK: begin
          state_d = ST_IDLE;
          if (b != SC_LSHIFT && b != SC_RSHIFT) begin
            load   = 1'b1;
            ld_ext = 1'b1;
            ld_brk = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (b != pause_byte(pcnt - 3'd1)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (pcnt == PAUSE_LAST) begin
            load    = 1'b1;
            ld_ext  = 1'b1;
            state_d = ST_IDLE;
          end else pcnt_d = pcnt + 3'd1;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout && state != ST_IDLE) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end
  end

  // A completed Pause carries code 77 regardless of the last byte's meaning.
  assign ld_mask = mod_mask((state == ST_PAUSE) ? SC_PAUSE : b, ld_ext);

  always_ff @(posedge clk6x) begin
    if (reset) begin
      state      <= ST_IDLE;
      pcnt       <= '0;
      bubble     <= 1'b0;
      err_o      <= 1'b0;
      ev_valid_o <= 1'b0;
      ev_code_o  <= '0;
      ev_ext_o   <= 1'b0;
      ev_brk_o   <= 1'b0;
      mod_o      <= '0;
    end else begin
      state      <= state_d;
      pcnt       <= pcnt_d;
      bubble     <= pop;
      err_o      <= err_d;
      ev_valid_o <= load || stall;
      if (load) begin
        ev_code_o <= (state == ST_PAUSE) ? SC_PAUSE : b;
        ev_ext_o  <= ld_ext;
        ev_brk_o  <= ld_brk;
        mod_o     <= ld_brk ? (mod_o & ~ld_mask) : (mod_o | ld_mask);
      end
    end
  end

endmodule
